// File: rtl/clk_frame_gen.sv
// Free-running frame / PRI timing generator: frame-aligned PRI pulses plus
// start/end-of-frame markers, all registered one cycle after the counter decode.
module clk_frame_gen #(
  parameter int FRAME_CYCLES = 100000,
  parameter int PRI_CYCLES   = 1000,
  parameter int PRI_WIDTH    = 1
) (
  input  logic clk,
  input  logic reset,
  output logic start_of_frame,
  output logic pulse_repetition_interval,
  output logic end_of_frame
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int PW = $clog2(PRI_CYCLES);

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0] PRI_LAST   = PW'(PRI_CYCLES - 1);
  localparam logic [PW-1:0] PRI_HIGH   = PW'(PRI_WIDTH);

  if ((PRI_CYCLES < 2) || (PRI_WIDTH < 1) || (PRI_WIDTH >= PRI_CYCLES) ||
      (FRAME_CYCLES < PRI_CYCLES) || ((FRAME_CYCLES % PRI_CYCLES) != 0)) begin : g_bad_params
    $error("clk_frame_gen: illegal FRAME_CYCLES/PRI_CYCLES/PRI_WIDTH combination");
  end

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] pri_cnt_q, pri_cnt_d;
  logic          sof_q, sof_d;
  logic          pri_q, pri_d;
  logic          eof_q, eof_d;
  logic          run;
  logic          frame_wrap;
  logic          pri_wrap;

  // Release is seen two edges late; assertion clears everything at once.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run        = rst_sync_q[1];

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pri_cnt_d   = pri_cnt_q;
    sof_d       = 1'b0;
    pri_d       = 1'b0;
    eof_d       = 1'b0;
    frame_wrap  = (frame_cnt_q == FRAME_LAST);
    pri_wrap    = (pri_cnt_q == PRI_LAST);
    if (run) begin
      sof_d       = (frame_cnt_q == '0);
      eof_d       = frame_wrap;
      pri_d       = (pri_cnt_q < PRI_HIGH);
      frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
      // Frame wrap also realigns the PRI slot grid.
      pri_cnt_d   = (frame_wrap || pri_wrap) ? '0 : pri_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q  <= '0;
      frame_cnt_q <= '0;
      pri_cnt_q   <= '0;
      sof_q       <= 1'b0;
      pri_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      rst_sync_q  <= rst_sync_d;
      frame_cnt_q <= frame_cnt_d;
      pri_cnt_q   <= pri_cnt_d;
      sof_q       <= sof_d;
      pri_q       <= pri_d;
      eof_q       <= eof_d;
    end
  end

  assign start_of_frame            = sof_q;
  assign pulse_repetition_interval = pri_q;
  assign end_of_frame              = eof_q;

endmodule

// File: tb/tb_clk_frame_gen.sv
// Scoreboard bench for clk_frame_gen: expected pulse events are queued at each
// reset release; a negedge monitor pops one entry per cycle with any output high.
module tb_clk_frame_gen;

  localparam int F0 = 2000, P0 = 100, W0 = 1;
  localparam int F1 = 100,  P1 = 20,  W1 = 5;
  localparam int F2 = 4,    P2 = 4,   W2 = 1;

  typedef struct {
    int cyc;
    bit sof;
    bit pri;
    bit eof;
  } ev_t;

  logic clk;
  logic reset;
  logic sof0, pri0, eof0;
  logic sof1, pri1, eof1;
  logic sof2, pri2, eof2;

  int cyc;
  int passed;
  int total;
  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  clk_frame_gen #(.FRAME_CYCLES(F0), .PRI_CYCLES(P0), .PRI_WIDTH(W0)) u_main (
    .clk(clk), .reset(reset),
    .start_of_frame(sof0), .pulse_repetition_interval(pri0), .end_of_frame(eof0));

  clk_frame_gen #(.FRAME_CYCLES(F1), .PRI_CYCLES(P1), .PRI_WIDTH(W1)) u_wide (
    .clk(clk), .reset(reset),
    .start_of_frame(sof1), .pulse_repetition_interval(pri1), .end_of_frame(eof1));

  clk_frame_gen #(.FRAME_CYCLES(F2), .PRI_CYCLES(P2), .PRI_WIDTH(W2)) u_tiny (
    .clk(clk), .reset(reset),
    .start_of_frame(sof2), .pulse_repetition_interval(pri2), .end_of_frame(eof2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int n, input int f, input int p, input int w);
    ev_t x;
    int fc;
    fc    = n % f;
    x.cyc = c;
    x.sof = (fc == 0);
    x.eof = (fc == f - 1);
    x.pri = ((fc % p) < w);
    return x;
  endfunction

  // Expected events for samples k0 .. k0+len-1 (count value n = 0 at k0).
  task automatic push_seg(input int k0, input int len);
    ev_t x;
    for (int n = 0; n < len; n++) begin
      x = mk(k0 + n, n, F0, P0, W0);
      if (x.sof || x.pri || x.eof) q0.push_back(x);
      x = mk(k0 + n, n, F1, P1, W1);
      if (x.sof || x.pri || x.eof) q1.push_back(x);
      x = mk(k0 + n, n, F2, P2, W2);
      if (x.sof || x.pri || x.eof) q2.push_back(x);
    end
  endtask

  task automatic chk_ev(input int inst, input logic s, input logic p, input logic e);
    ev_t x;
    bit have;
    have = 0;
    case (inst)
      0: if (q0.size() > 0) begin x = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin x = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1; end
    endcase
    total++;
    if (!have)
      $display("FAIL unexpected_pulse inst%0d: actual cyc=%0d sof/pri/eof=%b%b%b, required no pulse",
               inst, cyc, s, p, e);
    else if (x.cyc == cyc && x.sof == s && x.pri == p && x.eof == e)
      passed++;
    else
      $display("FAIL pulse inst%0d: actual cyc=%0d sof/pri/eof=%b%b%b, required cyc=%0d sof/pri/eof=%b%b%b",
               inst, cyc, s, p, e, x.cyc, x.sof, x.pri, x.eof);
  endtask

  task automatic chk_val(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    if (sof0 || pri0 || eof0) chk_ev(0, sof0, pri0, eof0);
    if (sof1 || pri1 || eof1) chk_ev(1, sof1, pri1, eof1);
    if (sof2 || pri2 || eof2) chk_ev(2, sof2, pri2, eof2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual cyc=%0d, required completion", cyc);
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k0;
    int k0b;
    int l1;
    int l2;
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    l1     = 5000;
    l2     = 4001;

    repeat (10) begin
      @(negedge clk);
      chk_val("in_reset_outputs", int'({sof0, pri0, eof0, sof1, pri1, eof1, sof2, pri2, eof2}), 0);
    end

    reset = 1'b1;
    k0    = cyc + 3;
    push_seg(k0, l1);

    // Abort at n = 5000: main instance is inside a PRI pulse at frame count 1000.
    while (cyc != k0 + l1 - 1) @(negedge clk);
    @(posedge clk);
    #1;
    chk_val("pri_before_abort", int'(pri0), 1);
    chk_val("sof_before_abort", int'(sof0), 0);
    #1 reset = 1'b0;
    #1;
    chk_val("async_clear_main", int'({sof0, pri0, eof0}), 0);
    chk_val("async_clear_wide", int'({sof1, pri1, eof1}), 0);
    chk_val("async_clear_tiny", int'({sof2, pri2, eof2}), 0);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    k0b   = cyc + 3;
    push_seg(k0b, l2);

    while (cyc != k0b + l2 - 1) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);

    chk_val("q_main_drained", q0.size(), 0);
    chk_val("q_wide_drained", q1.size(), 0);
    chk_val("q_tiny_drained", q2.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_frame_gen.md
CLK_FRAME_GEN -- requirements
Module: clk_frame_gen

Interface
REQ-001 Parameter FRAME_CYCLES, default 100000, frame length in clk cycles (1 ms at 100 MHz).
REQ-002 Parameter PRI_CYCLES, default 1000, pulse repetition interval in clk cycles (10 us at 100 MHz).
REQ-003 Parameter PRI_WIDTH, default 1, width of each PRI pulse in clk cycles.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start_of_frame  output  1  one-cycle pulse marking the first cycle of each frame.
REQ-007 pulse_repetition_interval  output  1  PRI_WIDTH-cycle pulse at the start of each PRI slot.
REQ-008 end_of_frame  output  1  one-cycle pulse marking the last cycle of each frame.

Function
REQ-009 Parameter legality: PRI_CYCLES >= 2; 1 <= PRI_WIDTH < PRI_CYCLES; FRAME_CYCLES = N*PRI_CYCLES with N >= 1; illegal values shall stop elaboration with an error.
REQ-010 Frame counter shall be ceil(log2(FRAME_CYCLES)) bits wide, count 0..FRAME_CYCLES-1 by +1 per cycle and wrap to 0 after FRAME_CYCLES-1.
REQ-011 PRI counter shall be ceil(log2(PRI_CYCLES)) bits wide, count 0..PRI_CYCLES-1 and wrap to 0; it shall also be forced to 0 whenever the frame counter wraps, so PRI slots are frame-aligned.
REQ-012 All three outputs shall be registered, decoded from the counter values, with exactly one cycle of latency.
REQ-013 Counter value n is used at the n-th rising edge after reset release (n=0 at the first edge), and the outputs update at that same edge.
REQ-014 start_of_frame shall be 1 for exactly one cycle following the edge at which the frame count is 0.
REQ-015 end_of_frame shall be 1 for exactly one cycle following the edge at which the frame count is FRAME_CYCLES-1.
REQ-016 end_of_frame shall be immediately followed, in the next cycle, by start_of_frame.
REQ-017 pulse_repetition_interval shall be 1 while the PRI count is in the range 0..PRI_WIDTH-1 (registered as per REQ-012) and 0 otherwise.
REQ-018 Exactly FRAME_CYCLES/PRI_CYCLES PRI pulses shall occur per frame.
REQ-019 The first PRI pulse of each frame shall coincide with start_of_frame.
REQ-020 start_of_frame and end_of_frame shall never be high in the same cycle when FRAME_CYCLES >= 2.
REQ-021 If FRAME_CYCLES = PRI_CYCLES, one PRI pulse shall occur per frame.
REQ-022 There shall be no input handshake or enable; the generator runs freely whenever reset is deasserted.

Reset
REQ-023 While reset = 0, both counters and all three outputs shall be 0 immediately (asynchronously), independent of clk.
REQ-024 Reset deassertion shall be synchronised internally with a two-flop synchroniser; counting shall begin at the first edge at which the synchronised reset is inactive.
REQ-025 Reset asserted mid-frame shall abort the frame with no end_of_frame pulse.
REQ-026 After release from a mid-frame reset, a new frame shall start per REQ-013/REQ-014.

Verification
REQ-027 Scenario: reset=0 for 10 cycles, then release -> all outputs 0 during reset; start_of_frame and pulse_repetition_interval both 1 in the same single cycle shortly after release (within synchroniser latency).
REQ-028 Scenario: defaults, run 3 ms -> start_of_frame period exactly 100000 cycles; end_of_frame exactly 1 cycle before each subsequent start_of_frame.
REQ-029 Scenario: defaults, run 1 frame -> exactly 100 PRI pulses, spaced 1000 cycles, each 1 cycle wide.
REQ-030 Scenario: PRI_WIDTH=5, PRI_CYCLES=20, FRAME_CYCLES=100 -> 5 PRI pulses per frame, each 5 cycles high, 15 cycles low.
REQ-031 Scenario: assert reset at frame count 50000, hold 3 cycles, release -> outputs 0 immediately on assertion; no end_of_frame for the aborted frame; next start_of_frame after release, then the normal 100000-cycle period resumes.
REQ-032 Scenario: FRAME_CYCLES=PRI_CYCLES=4 -> start_of_frame and pulse_repetition_interval both high 1 of every 4 cycles; end_of_frame high 3 cycles after each start_of_frame.
